gerador_imm_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RISC-V decode stage. It accepts one instruction word per cycle on a valid/ready handshake and decodes all RV base immediate formats: I, S, B, U and J. For each instruction it produces the sign-extended immediate, a format code and an illegal-opcode flag, registered and delivered through a two-entry skid buffer so back-pressure from execute never causes a loss or duplicate. It sits between instruction fetch and the register-read/ALU-operand mux, replacing the combinational generator.

---
 rtl/gerador_imm_pipe_if.sv | 24 ++
 rtl/gerador_imm_pipe.sv | 164 ++++++++++++++++
 tb/tb_gerador_imm_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gerador_imm_pipe_if.sv
// Decode-stage immediate generator bus: instruction handshake in, immediate handshake out.
// The slave modport is the generator's view; master is the fetch/execute side.
interface gerador_imm_pipe_if #(
  parameter int XLEN = 32
);
  logic            entrada_valida;
  logic            entrada_pronta;
  logic [31:0]     instr;
  logic            saida_valida;
  logic            saida_pronta;
  logic [XLEN-1:0] saida_imm;
  logic [2:0]      tipo_imm;
  logic            invalido;

  modport slave (
    input  entrada_valida, instr, saida_pronta,
    output entrada_pronta, saida_valida, saida_imm, tipo_imm, invalido
  );

  modport master (
    output entrada_valida, instr, saida_pronta,
    input  entrada_pronta, saida_valida, saida_imm, tipo_imm, invalido
  );
endinterface

// File: rtl/gerador_imm_pipe.sv
// Pipelined RISC-V immediate generator with a main entry plus one skid entry.
// state | meaning
// VAZIO | no result held, outputs invalid
// UM    | main entry valid, skid empty, accepting
// CHEIO | main and skid valid, not accepting
module gerador_imm_pipe #(
  parameter int XLEN       = 32,
  parameter bit SHAMT_MODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  gerador_imm_pipe_if.slave  bus
);

  localparam logic [1:0] VAZIO = 2'd0;
  localparam logic [1:0] UM    = 2'd1;
  localparam logic [1:0] CHEIO = 2'd2;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  // Entry layout: {invalido, tipo_imm, imm}
  localparam int EW = XLEN + 4;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [11:0] f_i;
  logic signed [11:0] f_s;
  logic signed [12:0] f_b;
  logic signed [31:0] f_u;
  logic signed [20:0] f_j;
  logic [XLEN-1:0]    shamt;
  logic               is_shift;

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_tipo;
  logic            dec_inv;
  logic [EW-1:0]   dec_w;

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] main_q, main_d;
  logic [EW-1:0] skid_q, skid_d;
  logic          pronta_q, pronta_d;
  logic          accept, drain, valida;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];

  assign f_i = bus.instr[31:20];
  assign f_s = {bus.instr[31:25], bus.instr[11:7]};
  assign f_b = {bus.instr[31], bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign f_u = {bus.instr[31:12], 12'b0};
  assign f_j = {bus.instr[31], bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};

  // Shift amount width follows XLEN: 5 bits on RV32, 6 bits on RV64
  assign shamt    = (XLEN == 64) ? XLEN'(bus.instr[25:20]) : XLEN'(bus.instr[24:20]);
  assign is_shift = SHAMT_MODE && ((funct3 == 3'b001) || (funct3 == 3'b101));

  always_comb begin
    dec_imm  = '0;
    dec_tipo = T_NONE;
    dec_inv  = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_imm  = XLEN'(f_i);
        dec_tipo = T_I;
      end
      7'b0010011: begin
        dec_imm  = is_shift ? shamt : XLEN'(f_i);
        dec_tipo = T_I;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_imm  = is_shift ? shamt : XLEN'(f_i);
          dec_tipo = T_I;
        end else begin
          dec_inv = 1'b1;
        end
      end
      7'b0100011: begin
        dec_imm  = XLEN'(f_s);
        dec_tipo = T_S;
      end
      7'b1100011: begin
        dec_imm  = XLEN'(f_b);
        dec_tipo = T_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm  = XLEN'(f_u);
        dec_tipo = T_U;
      end
      7'b1101111: begin
        dec_imm  = XLEN'(f_j);
        dec_tipo = T_J;
      end
      default: dec_inv = 1'b1;
    endcase
  end

  assign dec_w = {dec_inv, dec_tipo, dec_imm};

  assign valida = (state_q != VAZIO);
  assign accept = bus.entrada_valida && pronta_q;
  assign drain  = valida && bus.saida_pronta;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      VAZIO: begin
        if (accept) begin
          main_d  = dec_w;
          state_d = UM;
        end
      end
      UM: begin
        if (accept && drain) begin
          main_d = dec_w;
        end else if (accept) begin
          skid_d  = dec_w;
          state_d = CHEIO;
        end else if (drain) begin
          state_d = VAZIO;
        end
      end
      CHEIO: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = UM;
        end
      end
      default: state_d = VAZIO;
    endcase
  end

  // Ready is registered from the next state so saida_pronta never reaches it combinationally
  assign pronta_d = (state_d != CHEIO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= VAZIO;
      main_q   <= '0;
      skid_q   <= '0;
      pronta_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      pronta_q <= pronta_d;
    end
  end

  assign bus.entrada_pronta = pronta_q;
  assign bus.saida_valida   = valida;
  assign bus.saida_imm      = main_q[XLEN-1:0];
  assign bus.tipo_imm       = main_q[XLEN+2:XLEN];
  assign bus.invalido       = main_q[XLEN+3];

endmodule

// File: tb/tb_gerador_imm_pipe.sv
// Directed bench for gerador_imm_pipe: RV32 with and without shamt decoding, plus RV64.
module tb_gerador_imm_pipe;

  logic        clk;
  logic        rst_n;
  logic        valid_s;
  logic        pronta_s;
  logic [31:0] instr_s;

  int n_pass;
  int n_tot;

  gerador_imm_pipe_if #(.XLEN(32)) bus32 ();
  gerador_imm_pipe_if #(.XLEN(32)) bus_s0 ();
  gerador_imm_pipe_if #(.XLEN(64)) bus64 ();

  assign bus32.entrada_valida  = valid_s;
  assign bus32.instr           = instr_s;
  assign bus32.saida_pronta    = pronta_s;
  assign bus_s0.entrada_valida = valid_s;
  assign bus_s0.instr          = instr_s;
  assign bus_s0.saida_pronta   = pronta_s;
  assign bus64.entrada_valida  = valid_s;
  assign bus64.instr           = instr_s;
  assign bus64.saida_pronta    = pronta_s;

  gerador_imm_pipe #(.XLEN(32), .SHAMT_MODE(1'b1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  gerador_imm_pipe #(.XLEN(32), .SHAMT_MODE(1'b0)) dut_s0 (.clk(clk), .rst_n(rst_n), .bus(bus_s0));
  gerador_imm_pipe #(.XLEN(64), .SHAMT_MODE(1'b1)) dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    valid_s = 1'b1;
    instr_s = w;
    step();
  endtask

  task automatic chk32(input string tag, input logic [31:0] imm, input logic [2:0] tipo,
                       input logic inv);
    chk({tag, ".valid"}, 64'(bus32.saida_valida), 64'd1);
    chk({tag, ".imm"},   64'(bus32.saida_imm),    64'(imm));
    chk({tag, ".tipo"},  64'(bus32.tipo_imm),     64'(tipo));
    chk({tag, ".inv"},   64'(bus32.invalido),     64'(inv));
  endtask

  initial begin
    n_pass   = 0;
    n_tot    = 0;
    rst_n    = 1'b0;
    valid_s  = 1'b0;
    pronta_s = 1'b1;
    instr_s  = '0;

    #12;
    chk("rst.valid",  64'(bus32.saida_valida),   64'd0);
    chk("rst.pronta", 64'(bus32.entrada_pronta), 64'd1);
    chk("rst.imm",    64'(bus32.saida_imm),      64'd0);
    chk("rst.tipo",   64'(bus32.tipo_imm),       64'd0);
    chk("rst.inv",    64'(bus32.invalido),       64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Back-to-back stream, one result per cycle
    push(32'hFFC12083);
    chk32("lw", 32'hFFFFFFFC, 3'd1, 1'b0);
    chk("lw64.imm", bus64.saida_imm, 64'hFFFFFFFFFFFFFFFC);
    push(32'h00512423);
    chk32("sw", 32'h00000008, 3'd2, 1'b0);
    push(32'hFE000CE3);
    chk32("beq", 32'hFFFFFFF8, 3'd3, 1'b0);
    push(32'h123450B7);
    chk32("lui", 32'h12345000, 3'd4, 1'b0);
    chk("lui64.imm", bus64.saida_imm, 64'h0000000012345000);
    push(32'hFFDFF06F);
    chk32("jal", 32'hFFFFFFFC, 3'd5, 1'b0);
    push(32'h00309093);
    chk32("slli", 32'h00000003, 3'd1, 1'b0);
    push(32'h4030D093);
    chk32("srai", 32'h00000003, 3'd1, 1'b0);
    chk("srai_s0.imm", 64'(bus_s0.saida_imm), 64'h403);
    chk("srai64.imm",  bus64.saida_imm,       64'h3);
    push(32'h0000007F);
    chk32("ilegal", 32'h0, 3'd0, 1'b1);
    push(32'hFFF1009B);
    chk32("addiw32", 32'h0, 3'd0, 1'b1);
    chk("addiw64.imm",  bus64.saida_imm,      64'hFFFFFFFFFFFFFFFF);
    chk("addiw64.tipo", 64'(bus64.tipo_imm),  64'd1);
    chk("addiw64.inv",  64'(bus64.invalido),  64'd0);
    valid_s = 1'b0;
    step();
    chk("idle.valid", 64'(bus32.saida_valida), 64'd0);

    // Back-pressure: A, B accepted, C stalls until the skid drains
    pronta_s = 1'b0;
    push(32'h00512423);
    chk("bp.a.pronta", 64'(bus32.entrada_pronta), 64'd1);
    chk32("bp.a", 32'h00000008, 3'd2, 1'b0);
    push(32'h123450B7);
    chk("bp.b.pronta", 64'(bus32.entrada_pronta), 64'd0);
    chk32("bp.hold1", 32'h00000008, 3'd2, 1'b0);
    push(32'hFE000CE3);
    chk("bp.c.pronta", 64'(bus32.entrada_pronta), 64'd0);
    chk32("bp.hold2", 32'h00000008, 3'd2, 1'b0);
    pronta_s = 1'b1;
    step();
    chk32("bp.outb", 32'h12345000, 3'd4, 1'b0);
    chk("bp.outb.pronta", 64'(bus32.entrada_pronta), 64'd1);
    step();
    chk32("bp.outc", 32'hFFFFFFF8, 3'd3, 1'b0);
    valid_s = 1'b0;
    step();
    chk("bp.empty", 64'(bus32.saida_valida), 64'd0);

    // Full throughput: accept and drain on every edge
    for (int i = 0; i < 16; i++) begin
      push({12'(i + 1), 5'd1, 3'b000, 5'd2, 7'b0010011});
      chk32($sformatf("thr%0d", i), 32'(i + 1), 3'd1, 1'b0);
      chk($sformatf("thr%0d.pronta", i), 64'(bus32.entrada_pronta), 64'd1);
    end
    valid_s = 1'b0;
    step();
    chk("thr.empty", 64'(bus32.saida_valida), 64'd0);

    // Asynchronous reset while both entries are full
    pronta_s = 1'b0;
    push(32'h00512423);
    push(32'h123450B7);
    chk("mid.full.pronta", 64'(bus32.entrada_pronta), 64'd0);
    valid_s = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.rst.valid",  64'(bus32.saida_valida),   64'd0);
    chk("mid.rst.pronta", 64'(bus32.entrada_pronta), 64'd1);
    chk("mid.rst.imm",    64'(bus32.saida_imm),      64'd0);
    chk("mid.rst.tipo",   64'(bus32.tipo_imm),       64'd0);
    step();
    rst_n    = 1'b1;
    pronta_s = 1'b1;
    step();
    chk("mid.post.valid", 64'(bus32.saida_valida), 64'd0);
    push(32'hFFDFF06F);
    chk32("mid.first", 32'hFFFFFFFC, 3'd5, 1'b0);
    valid_s = 1'b0;
    step();
    chk("mid.drained", 64'(bus32.saida_valida), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
